// File: rtl/hnoc_pkg.sv
// ============================================================================
// hnoc_pkg: shared HNoC flit layout, address constants and flit helpers. rev 1.0
// ============================================================================
`default_nettype none

package hnoc_pkg;

  localparam int ADDR_WIDTH    = 3;
  localparam int NUM_PE        = 1 << ADDR_WIDTH;
  localparam int DATA_WIDTH    = 32;
  localparam int CNT_WIDTH     = 16;

  localparam int DEST_MSB      = 31;
  localparam int DEST_LSB      = 29;
  localparam int SRC_MSB       = 28;
  localparam int SRC_LSB       = 26;
  localparam int PAYLOAD_MSB   = 25;
  localparam int PAYLOAD_WIDTH = PAYLOAD_MSB + 1;

  typedef logic [DATA_WIDTH-1:0]    flit_t;
  typedef logic [ADDR_WIDTH-1:0]    addr_t;
  typedef logic [PAYLOAD_WIDTH-1:0] payload_t;

  // What the rx buffer holds once the header has been stripped
  typedef struct packed {
    addr_t    src;
    payload_t payload;
  } rx_entry_t;

  function automatic flit_t make_flit(input addr_t dest, input addr_t src, input payload_t payload);
    flit_t f;
    f                       = '0;
    f[DEST_MSB:DEST_LSB]    = dest;
    f[SRC_MSB:SRC_LSB]      = src;
    f[PAYLOAD_MSB:0]        = payload;
    return f;
  endfunction

  function automatic addr_t flit_dest(input flit_t f);
    return f[DEST_MSB:DEST_LSB];
  endfunction

  function automatic addr_t flit_src(input flit_t f);
    return f[SRC_MSB:SRC_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/hnoc_sync_fifo.sv
// ============================================================================
// hnoc_sync_fifo: first-word-fall-through FIFO, power-of-2 depth, async reset. rev 1.0
// ============================================================================
`default_nettype none

module hnoc_sync_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_WIDTH = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CNT_W     = $clog2(Depth + 1);

  logic [Width-1:0]     mem [Depth];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == CNT_W'(Depth));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is cleared too so the read port shows zero while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_noc_interface.sv
// ============================================================================
// pe_noc_interface: PE <-> HNoC port adapter with tx FIFO, filtered rx buffer, stats. rev 1.0
// ============================================================================
`default_nettype none

module pe_noc_interface
  import hnoc_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddrWidth    = 3,
  parameter int MyAddr       = 0,
  parameter int TxDepth      = 4,
  localparam int PayloadWidth = DataWidth - 2 * AddrWidth
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [PayloadWidth-1:0] i_tx_payload,
  input  logic [AddrWidth-1:0]    i_tx_dest,
  input  logic                    i_tx_valid,
  output logic                    o_tx_ready,
  output logic [DataWidth-1:0]    o_noc_data,
  output logic                    o_noc_data_valid,
  input  logic                    i_noc_data_ready,
  input  logic [DataWidth-1:0]    i_noc_data,
  input  logic                    i_noc_data_valid,
  output logic                    o_noc_data_ready,
  output logic [PayloadWidth-1:0] o_rx_payload,
  output logic [AddrWidth-1:0]    o_rx_src,
  output logic                    o_rx_valid,
  input  logic                    i_rx_ready,
  output logic [15:0]             o_tx_count,
  output logic [15:0]             o_rx_count,
  output logic [15:0]             o_drop_count
);

  localparam addr_t MY_ADDR = addr_t'(MyAddr % NUM_PE);
  localparam int    RX_W    = PayloadWidth + AddrWidth;

  logic                 running;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_push;
  logic                 tx_pop;
  flit_t                tx_flit;
  logic                 rx_full;
  logic                 rx_empty;
  logic                 rx_accept;
  logic                 rx_match;
  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_drop;
  rx_entry_t            rx_in;
  rx_entry_t            rx_out;
  logic [RX_W-1:0]      rx_out_bits;
  logic [CNT_WIDTH-1:0] tx_cnt;
  logic [CNT_WIDTH-1:0] rx_cnt;
  logic [CNT_WIDTH-1:0] drop_cnt;

  // Holds both readies low for the first cycle after reset is released
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      running <= 1'b0;
    end else begin
      running <= 1'b1;
    end
  end

  assign o_tx_ready       = running && !tx_full;
  assign tx_push          = i_tx_valid && o_tx_ready;
  assign tx_flit          = make_flit(i_tx_dest, MY_ADDR, i_tx_payload);
  assign o_noc_data_valid = !tx_empty;
  assign tx_pop           = o_noc_data_valid && i_noc_data_ready;

  hnoc_sync_fifo #(
    .Width (DataWidth),
    .Depth (TxDepth)
  ) u_tx_fifo (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .push      (tx_push),
    .push_data (tx_flit),
    .pop       (tx_pop),
    .pop_data  (o_noc_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign o_noc_data_ready = running && !rx_full;
  assign rx_accept        = i_noc_data_valid && o_noc_data_ready;
  assign rx_match         = (flit_dest(i_noc_data) == MY_ADDR);
  assign rx_push          = rx_accept && rx_match;
  assign rx_drop          = rx_accept && !rx_match;
  assign rx_in.src        = flit_src(i_noc_data);
  assign rx_in.payload    = i_noc_data[PAYLOAD_MSB:0];
  assign o_rx_valid       = !rx_empty;
  assign rx_pop           = o_rx_valid && i_rx_ready;

  hnoc_sync_fifo #(
    .Width (RX_W),
    .Depth (2)
  ) u_rx_fifo (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .push      (rx_push),
    .push_data (rx_in),
    .pop       (rx_pop),
    .pop_data  (rx_out_bits),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign rx_out       = rx_entry_t'(rx_out_bits);
  assign o_rx_payload = rx_out.payload;
  assign o_rx_src     = rx_out.src;

  // Statistics stick at all-ones rather than wrapping
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (tx_pop && (tx_cnt != '1)) begin
        tx_cnt <= tx_cnt + CNT_WIDTH'(1);
      end
      if (rx_pop && (rx_cnt != '1)) begin
        rx_cnt <= rx_cnt + CNT_WIDTH'(1);
      end
      if (rx_drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_tx_count   = tx_cnt;
  assign o_rx_count   = rx_cnt;
  assign o_drop_count = drop_cnt;

endmodule

`default_nettype wire
